// File: rtl/rpn_exec.sv
// RPN execution unit: takes the three stacked entries (A, B, operator) and
// computes ALU, shift-add multiply and restoring divide results with flags.
module rpn_exec #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [1:0]       Count,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [7:0]       Op,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic             Busy,
  output logic             Done,
  output logic             Err,
  output logic             Z,
  output logic             N,
  output logic             C
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam logic [2:0] OP_DIV = 3'd6;
  localparam logic [2:0] OP_MOD = 3'd7;

  state_t      state_r;
  logic [7:0]  a_r;
  logic [7:0]  b_r;
  logic [2:0]  op_r;
  logic [3:0]  cnt_r;
  // MUL: {partial high, remaining multiplier}; DIV/MOD: {remainder, dividend->quotient}
  logic [15:0] acc_r;

  logic [8:0]  sum_s;
  logic [8:0]  diff_s;
  logic [8:0]  mul_sum_s;
  logic [15:0] mul_next_s;
  logic [8:0]  div_shift_s;
  logic        div_ge_s;
  logic [7:0]  div_rem_s;
  logic [15:0] div_next_s;
  logic        last_s;
  logic        fin_s;
  logic [7:0]  lo_s;
  logic [7:0]  hi_s;
  logic        c_s;
  logic        err_s;
  logic [15:0] acc_nxt_s;

  // Datapath: one iteration step and the result/flags offered to the DONE transition
  always_comb begin
    sum_s       = {1'b0, a_r} + {1'b0, b_r};
    diff_s      = {1'b0, a_r} - {1'b0, b_r};
    mul_sum_s   = {1'b0, acc_r[15:8]} + (acc_r[0] ? {1'b0, a_r} : 9'd0);
    mul_next_s  = {mul_sum_s, acc_r[7:1]};
    div_shift_s = acc_r[15:7];
    div_ge_s    = (div_shift_s >= {1'b0, b_r});
    div_rem_s   = div_ge_s ? (div_shift_s[7:0] - b_r) : div_shift_s[7:0];
    div_next_s  = {div_rem_s, acc_r[6:0], div_ge_s};
    last_s      = (cnt_r == 4'd7);
    fin_s       = 1'b1;
    lo_s        = 8'd0;
    hi_s        = 8'd0;
    c_s         = 1'b0;
    err_s       = 1'b0;
    acc_nxt_s   = acc_r;
    case (op_r)
      OP_ADD: begin
        lo_s = sum_s[7:0];
        c_s  = sum_s[8];
      end
      OP_SUB: begin
        lo_s = diff_s[7:0];
        c_s  = diff_s[8];
      end
      OP_AND: lo_s = a_r & b_r;
      OP_OR:  lo_s = a_r | b_r;
      OP_XOR: lo_s = a_r ^ b_r;
      OP_MUL: begin
        acc_nxt_s = mul_next_s;
        fin_s     = last_s;
        lo_s      = mul_next_s[7:0];
        hi_s      = mul_next_s[15:8];
        c_s       = (mul_next_s[15:8] != 8'd0);
      end
      OP_DIV, OP_MOD: begin
        if (b_r == 8'd0) begin
          err_s = 1'b1;
          lo_s  = 8'hFF;
          hi_s  = a_r;
        end else begin
          acc_nxt_s = div_next_s;
          fin_s     = last_s;
          if (op_r == OP_DIV) begin
            lo_s = div_next_s[7:0];
            hi_s = div_next_s[15:8];
          end else begin
            lo_s = div_next_s[15:8];
            hi_s = 8'd0;
          end
        end
      end
      default: begin
        lo_s  = 8'd0;
        err_s = 1'b1;
      end
    endcase
  end

  // Control FSM with registered status and result outputs
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_r  <= ST_IDLE;
      a_r      <= 8'd0;
      b_r      <= 8'd0;
      op_r     <= 3'd0;
      cnt_r    <= 4'd0;
      acc_r    <= 16'd0;
      Result   <= 8'd0;
      ResultHi <= 8'd0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Err      <= 1'b0;
      Z        <= 1'b1;
      N        <= 1'b0;
      C        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            a_r   <= A;
            b_r   <= B;
            op_r  <= Op[2:0];
            cnt_r <= 4'd0;
            acc_r <= (Op[2] && Op[1]) ? {8'd0, A} : {8'd0, B};
            if ((Count != 2'd3) || (Op[7:3] != 5'd0)) begin
              state_r  <= ST_DONE;
              Done     <= 1'b1;
              Result   <= 8'd0;
              ResultHi <= 8'd0;
              Err      <= 1'b1;
              Z        <= 1'b1;
              N        <= 1'b0;
              C        <= 1'b0;
            end else begin
              state_r <= ST_EXEC;
              Busy    <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          if (fin_s) begin
            state_r  <= ST_DONE;
            Busy     <= 1'b0;
            Done     <= 1'b1;
            Result   <= lo_s;
            ResultHi <= hi_s;
            Err      <= err_s;
            Z        <= (lo_s == 8'd0);
            N        <= lo_s[7];
            C        <= c_s;
          end else begin
            acc_r <= acc_nxt_s;
            cnt_r <= cnt_r + 4'd1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          Done    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          Busy    <= 1'b0;
          Done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_exec.sv
// Scoreboard bench for rpn_exec: a behavioural model pushes expected results
// at Start, and each scenario pops and compares when Done appears.
module tb_rpn_exec;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Start;
  logic [1:0] Count;
  logic [7:0] A;
  logic [7:0] B;
  logic [7:0] Op;
  logic [7:0] Result;
  logic [7:0] ResultHi;
  logic       Busy;
  logic       Done;
  logic       Err;
  logic       Z;
  logic       N;
  logic       C;

  int total = 0;
  int bad   = 0;
  logic [19:0] sb[$];

  rpn_exec #(.WIDTH(8)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Count(Count), .A(A), .B(B), .Op(Op),
    .Result(Result), .ResultHi(ResultHi), .Busy(Busy), .Done(Done),
    .Err(Err), .Z(Z), .N(N), .C(C)
  );

  always #5 Clk = ~Clk;

  // Expected {ResultHi, Result, Err, Z, N, C}
  function automatic logic [19:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] op, input logic [1:0] cnt);
    logic [7:0] lo, hi;
    logic e, c;
    logic [15:0] p;
    logic [8:0] s;
    lo = 8'd0; hi = 8'd0; e = 1'b0; c = 1'b0;
    if (cnt != 2'd3 || op > 8'd7) begin
      e = 1'b1;
    end else begin
      case (op[2:0])
        3'd0: begin s = {1'b0, a} + {1'b0, b}; lo = s[7:0]; c = s[8]; end
        3'd1: begin lo = a - b; c = (a < b); end
        3'd2: lo = a & b;
        3'd3: lo = a | b;
        3'd4: lo = a ^ b;
        3'd5: begin p = {8'd0, a} * {8'd0, b}; lo = p[7:0]; hi = p[15:8]; c = (hi != 8'd0); end
        3'd6: if (b == 8'd0) begin e = 1'b1; lo = 8'hFF; hi = a; end
              else begin lo = a / b; hi = a % b; end
        default: if (b == 8'd0) begin e = 1'b1; lo = 8'hFF; hi = a; end
                 else begin lo = a % b; hi = 8'd0; end
      endcase
    end
    return {hi, lo, e, (lo == 8'd0), lo[7], c};
  endfunction

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                        input logic [1:0] cnt, output int lat, output int busy_cyc,
                        output logic [19:0] obs);
    @(negedge Clk);
    A = a; B = b; Op = op; Count = cnt; Start = 1'b1;
    sb.push_back(model(a, b, op, cnt));
    @(posedge Clk);
    #1 Start = 1'b0;
    lat = -1; busy_cyc = 0; obs = 20'bx;
    for (int i = 1; i <= 40; i++) begin
      @(negedge Clk);
      if (Busy) busy_cyc++;
      if (Done) begin
        lat = i;
        obs = {ResultHi, Result, Err, Z, N, C};
        break;
      end
    end
  endtask

  task automatic test_reset();
    Rst = 1'b0; Start = 1'b0; Count = 2'd0; A = 8'd0; B = 8'd0; Op = 8'd0;
    #12;
    total++;
    if ({Result, ResultHi, Err, Z, N, C, Busy, Done} !== {8'd0, 8'd0, 1'b0, 1'b1, 4'b0000}) begin
      bad++;
      $display("FAIL reset_state got=%h want=%h", {Result, ResultHi, Err, Z, N, C, Busy, Done}, {16'd0, 6'b010000});
    end
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  task automatic test_alu();
    logic [7:0] ta[6] = '{8'hF0, 8'h05, 8'h07, 8'hA5, 8'hA5, 8'hA5};
    logic [7:0] tb[6] = '{8'h20, 8'h07, 8'h07, 8'h0F, 8'h0F, 8'hFF};
    logic [7:0] to[6] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4};
    int lat, bc;
    logic [19:0] obs, exp;
    for (int i = 0; i < 6; i++) begin
      run_op(ta[i], tb[i], to[i], 2'd3, lat, bc, obs);
      exp = sb.pop_front();
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL alu_%0d got=%h want=%h", i, obs, exp);
      end
      total++;
      if (lat !== 2 || bc !== 1) begin
        bad++;
        $display("FAIL alu_lat_%0d got lat=%0d busy=%0d want lat=2 busy=1", i, lat, bc);
      end
      if (i == 0) begin
        total++;
        if (obs !== 20'h00101) begin
          bad++;
          $display("FAIL add_f0_20 got=%h want=00101", obs);
        end
      end
    end
  endtask

  task automatic test_mul();
    logic [7:0] ta[4] = '{8'd200, 8'd255, 8'd0, 8'd1};
    logic [7:0] tb[4] = '{8'd3, 8'd255, 8'd77, 8'd128};
    int lat, bc;
    logic [19:0] obs, exp;
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], 8'd5, 2'd3, lat, bc, obs);
      exp = sb.pop_front();
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL mul_%0d got=%h want=%h", i, obs, exp);
      end
      total++;
      if (lat !== 9 || bc !== 8) begin
        bad++;
        $display("FAIL mul_lat_%0d got lat=%0d busy=%0d want lat=9 busy=8", i, lat, bc);
      end
      if (i == 0) begin
        total++;
        if (obs !== 20'h02581) begin
          bad++;
          $display("FAIL mul_200x3 got=%h want=02581", obs);
        end
      end
    end
  endtask

  task automatic test_div();
    logic [7:0] ta[7] = '{8'd200, 8'd200, 8'd200, 8'd200, 8'd255, 8'd5, 8'd255};
    logic [7:0] tb[7] = '{8'd7, 8'd7, 8'd0, 8'd0, 8'd1, 8'd200, 8'd16};
    logic [7:0] to[7] = '{8'd6, 8'd7, 8'd6, 8'd7, 8'd6, 8'd6, 8'd7};
    int lat, bc, want_lat;
    logic [19:0] obs, exp;
    for (int i = 0; i < 7; i++) begin
      run_op(ta[i], tb[i], to[i], 2'd3, lat, bc, obs);
      exp = sb.pop_front();
      want_lat = (tb[i] == 8'd0) ? 2 : 9;
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL div_%0d got=%h want=%h", i, obs, exp);
      end
      total++;
      if (lat !== want_lat) begin
        bad++;
        $display("FAIL div_lat_%0d got=%0d want=%0d", i, lat, want_lat);
      end
    end
  endtask

  task automatic test_invalid();
    logic [1:0] tc[3] = '{2'd2, 2'd3, 2'd0};
    logic [7:0] to[3] = '{8'd0, 8'h08, 8'd5};
    int lat, bc;
    logic [19:0] obs, exp;
    for (int i = 0; i < 3; i++) begin
      run_op(8'h12, 8'h34, to[i], tc[i], lat, bc, obs);
      exp = sb.pop_front();
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL invalid_%0d got=%h want=%h", i, obs, exp);
      end
      total++;
      if (lat !== 1 || bc !== 0) begin
        bad++;
        $display("FAIL invalid_lat_%0d got lat=%0d busy=%0d want lat=1 busy=0", i, lat, bc);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, gap, extra;
    logic [19:0] obs, exp;
    @(negedge Clk);
    A = 8'd10; B = 8'd20; Op = 8'd0; Count = 2'd3; Start = 1'b1;
    sb.push_back(model(8'd10, 8'd20, 8'd0, 2'd3));
    lat = -1; obs = 20'bx;
    for (int i = 1; i <= 20; i++) begin
      @(negedge Clk);
      if (Done) begin lat = i; obs = {ResultHi, Result, Err, Z, N, C}; break; end
    end
    exp = sb.pop_front();
    total++;
    if (obs !== exp || lat !== 2) begin
      bad++;
      $display("FAIL b2b_first got=%h lat=%0d want=%h lat=2", obs, lat, exp);
    end
    A = 8'h80; B = 8'h80;
    sb.push_back(model(8'h80, 8'h80, 8'd0, 2'd3));
    gap = -1; obs = 20'bx;
    for (int i = 1; i <= 20; i++) begin
      @(negedge Clk);
      if (Done) begin gap = i; obs = {ResultHi, Result, Err, Z, N, C}; break; end
    end
    Start = 1'b0;
    exp = sb.pop_front();
    total++;
    if (obs !== exp || gap !== 3) begin
      bad++;
      $display("FAIL b2b_second got=%h gap=%0d want=%h gap=3", obs, gap, exp);
    end
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      if (Done) extra++;
    end
    total++;
    if (extra !== 0) begin
      bad++;
      $display("FAIL b2b_no_extra got=%0d want=0", extra);
    end
  endtask

  task automatic test_start_ignored();
    int lat, extra;
    logic [19:0] obs, exp;
    @(negedge Clk);
    A = 8'd200; B = 8'd3; Op = 8'd5; Count = 2'd3; Start = 1'b1;
    sb.push_back(model(8'd200, 8'd3, 8'd5, 2'd3));
    @(posedge Clk);
    #1 Start = 1'b0;
    lat = -1; obs = 20'bx;
    for (int i = 1; i <= 40; i++) begin
      @(negedge Clk);
      if (i >= 2 && i <= 4) begin A = 8'd1; B = 8'd1; Op = 8'd0; Start = 1'b1; end
      else Start = 1'b0;
      if (Done) begin lat = i; obs = {ResultHi, Result, Err, Z, N, C}; break; end
    end
    exp = sb.pop_front();
    total++;
    if (obs !== exp || lat !== 9) begin
      bad++;
      $display("FAIL ignore_start got=%h lat=%0d want=%h lat=9", obs, lat, exp);
    end
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      if (Done) extra++;
    end
    total++;
    if (extra !== 0 || {ResultHi, Result, Err, Z, N, C} !== exp) begin
      bad++;
      $display("FAIL ignore_hold got extra=%0d out=%h want extra=0 out=%h",
               extra, {ResultHi, Result, Err, Z, N, C}, exp);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc, seen;
    logic [19:0] obs, exp;
    @(negedge Clk);
    A = 8'd200; B = 8'd3; Op = 8'd5; Count = 2'd3; Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    repeat (4) @(negedge Clk);
    #2 Rst = 1'b0;
    #1;
    total++;
    if ({Result, ResultHi, Err, Z, N, C, Busy, Done} !== {16'd0, 6'b010000}) begin
      bad++;
      $display("FAIL reset_mid_state got=%h want=%h", {Result, ResultHi, Err, Z, N, C, Busy, Done}, {16'd0, 6'b010000});
    end
    seen = 0;
    repeat (2) begin
      @(negedge Clk);
      if (Done) seen++;
    end
    Rst = 1'b1;
    repeat (10) begin
      @(negedge Clk);
      if (Done || Busy) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL reset_mid_nodone got=%0d want=0", seen);
    end
    run_op(8'h33, 8'h44, 8'd0, 2'd3, lat, bc, obs);
    exp = sb.pop_front();
    total++;
    if (obs !== exp || lat !== 2) begin
      bad++;
      $display("FAIL reset_mid_add got=%h lat=%0d want=%h lat=2", obs, lat, exp);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mul();
    test_div();
    test_invalid();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
